// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit and the data memory:
// access size codes and the access-unit FSM state encoding.
package mem_pkg;

  localparam logic [1:0] WORD    = 2'b00;
  localparam logic [1:0] HALF    = 2'b01;
  localparam logic [1:0] ILLEGAL = 2'b10;
  localparam logic [1:0] BYTE    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    SPLIT  = 2'b10,
    RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of right-aligned load data by access size.
module mem_load_ext
  import mem_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] data,
  input  logic [1:0]         size,
  input  logic               zero_ext,
  output logic [NB_DATA-1:0] ext
);

  logic sign_b;
  logic sign_h;

  assign sign_b = data[7] & ~zero_ext;
  assign sign_h = data[15] & ~zero_ext;

  always_comb begin
    ext = data;
    case (size)
      BYTE:    ext = {{(NB_DATA-8){sign_b}}, data[7:0]};
      HALF:    ext = {{(NB_DATA-16){sign_h}}, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one native access when aligned, otherwise a
// sequence of byte accesses with wrap-around addressing.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int N_ADDRESS  = 64,
  parameter int NB_ADDRESS = $clog2(N_ADDRESS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [NB_ADDRESS-1:0] i_req_addr,
  input  logic [NB_DATA-1:0]    i_req_wdata,
  output logic                  o_resp_valid,
  output logic [NB_DATA-1:0]    o_resp_rdata,
  output logic                  o_resp_err,
  output logic [NB_ADDRESS-1:0] o_mem_r_addr,
  output logic [NB_ADDRESS-1:0] o_mem_w_addr,
  output logic                  o_mem_r_en,
  output logic                  o_mem_w_en,
  output logic [1:0]            o_mem_r_addressing,
  output logic [1:0]            o_mem_w_addressing,
  output logic [NB_DATA-1:0]    o_mem_w_data,
  input  logic [NB_DATA-1:0]    i_mem_r_data
);

  localparam logic [NB_ADDRESS:0] ADDR_LIMIT = (NB_ADDRESS+1)'(N_ADDRESS);

  state_e state;
  state_e state_next;

  logic                  req_we;
  logic                  req_uns;
  logic [1:0]            req_size;
  logic [NB_ADDRESS-1:0] req_addr;
  logic [NB_DATA-1:0]    req_wdata;
  logic [NB_DATA-1:0]    result;
  logic [1:0]            idx;

  logic                  aligned;
  logic                  last;
  logic [NB_ADDRESS:0]   addr_sum;
  logic [NB_ADDRESS-1:0] split_addr;
  logic [7:0]            split_byte;
  logic [NB_DATA-1:0]    load_data;

  always_comb begin
    aligned = 1'b1;
    unique case (1'b1)
      i_req_size == WORD: aligned = i_req_addr[1:0] == 2'b00;
      i_req_size == HALF: aligned = ~i_req_addr[0];
      default:            aligned = 1'b1;
    endcase
  end

  // Byte k of a split access lives at (addr + k) mod N_ADDRESS
  assign addr_sum = {1'b0, req_addr} + {{(NB_ADDRESS-1){1'b0}}, idx};
  assign split_addr = (addr_sum >= ADDR_LIMIT)
                    ? NB_ADDRESS'(addr_sum - ADDR_LIMIT)
                    : addr_sum[NB_ADDRESS-1:0];
  assign split_byte = req_wdata[8*idx +: 8];
  assign last = (idx == ((req_size == WORD) ? 2'd3 : 2'd1));

  mem_load_ext #(
    .NB_DATA (NB_DATA)
  ) u_load_ext (
    .data     (result),
    .size     (req_size),
    .zero_ext (req_uns),
    .ext      (load_data)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      req_we    <= 1'b0;
      req_uns   <= 1'b0;
      req_size  <= WORD;
      req_addr  <= '0;
      req_wdata <= '0;
      result    <= '0;
      idx       <= '0;
    end else begin
      if (state == IDLE && i_req_valid) begin
        req_we    <= i_req_we;
        req_uns   <= i_req_unsigned;
        req_size  <= i_req_size;
        req_addr  <= i_req_addr;
        req_wdata <= i_req_wdata;
        result    <= '0;
        idx       <= '0;
      end
      if (state == ACCESS && !req_we) result <= i_mem_r_data;
      if (state == SPLIT) begin
        if (!req_we) result[8*idx +: 8] <= i_mem_r_data[7:0];
        idx <= idx + 2'd1;
      end
    end
  end

  always_comb begin
    state_next         = state;
    o_req_ready        = 1'b0;
    o_resp_valid       = 1'b0;
    o_resp_rdata       = '0;
    o_resp_err         = 1'b0;
    o_mem_r_en         = 1'b0;
    o_mem_w_en         = 1'b0;
    o_mem_r_addr       = '0;
    o_mem_w_addr       = '0;
    o_mem_r_addressing = 2'b00;
    o_mem_w_addressing = 2'b00;
    o_mem_w_data       = '0;
    unique case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (i_req_size == ILLEGAL) state_next = RESP;
          else if (aligned)          state_next = ACCESS;
          else                       state_next = SPLIT;
        end
      end
      ACCESS: begin
        if (req_we) begin
          o_mem_w_en         = 1'b1;
          o_mem_w_addr       = req_addr;
          o_mem_w_addressing = req_size;
          o_mem_w_data       = req_wdata;
        end else begin
          o_mem_r_en         = 1'b1;
          o_mem_r_addr       = req_addr;
          o_mem_r_addressing = req_size;
        end
        state_next = RESP;
      end
      SPLIT: begin
        if (req_we) begin
          o_mem_w_en         = 1'b1;
          o_mem_w_addr       = split_addr;
          o_mem_w_addressing = BYTE;
          o_mem_w_data       = NB_DATA'(split_byte);
        end else begin
          o_mem_r_en         = 1'b1;
          o_mem_r_addr       = split_addr;
          o_mem_r_addressing = BYTE;
        end
        if (last) state_next = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        o_resp_err   = (req_size == ILLEGAL);
        if (!req_we && req_size != ILLEGAL) o_resp_rdata = load_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-byte little-endian memory.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [5:0]  r_addr;
  logic [5:0]  w_addr;
  logic        r_en;
  logic        w_en;
  logic [1:0]  r_addressing;
  logic [1:0]  w_addressing;
  logic [31:0] w_data;
  logic [31:0] r_data;

  logic [7:0]  mem [64];
  logic        mem_init;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(
    .NB_DATA   (32),
    .N_ADDRESS (64)
  ) dut (
    .i_clk              (clk),
    .i_reset            (rst),
    .i_req_valid        (req_valid),
    .o_req_ready        (req_ready),
    .i_req_we           (req_we),
    .i_req_size         (req_size),
    .i_req_unsigned     (req_uns),
    .i_req_addr         (req_addr),
    .i_req_wdata        (req_wdata),
    .o_resp_valid       (resp_valid),
    .o_resp_rdata       (resp_rdata),
    .o_resp_err         (resp_err),
    .o_mem_r_addr       (r_addr),
    .o_mem_w_addr       (w_addr),
    .o_mem_r_en         (r_en),
    .o_mem_w_en         (w_en),
    .o_mem_r_addressing (r_addressing),
    .o_mem_w_addressing (w_addressing),
    .o_mem_w_data       (w_data),
    .i_mem_r_data       (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 6-bit index arithmetic wraps around the 64-byte memory
  assign r_data = {mem[r_addr + 6'd3], mem[r_addr + 6'd2],
                   mem[r_addr + 6'd1], mem[r_addr]};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[8]  <= 8'h11;
      mem[9]  <= 8'h22;
      mem[10] <= 8'h33;
      mem[11] <= 8'h84;
      mem[63] <= 8'h80;
      mem[0]  <= 8'hF0;
    end else if (w_en) begin
      mem[w_addr] <= w_data[7:0];
      if (w_addressing != BYTE) mem[w_addr + 6'd1] <= w_data[15:8];
      if (w_addressing == WORD) begin
        mem[w_addr + 6'd2] <= w_data[23:16];
        mem[w_addr + 6'd3] <= w_data[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          k;
  } vec_t;

  vec_t vecs[23];

  task automatic run_vec(input vec_t v, input int n);
    logic [5:0]  ea;
    logic [1:0]  es;
    logic [31:0] ed;
    logic        m;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_uns   = v.uns;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    chk($sformatf("v%0d ready_idle", n), 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= v.k + 1; c++) begin
      @(negedge clk);
      m  = (c <= v.k);
      ea = (v.k == 1) ? v.addr : v.addr + 6'(c - 1);
      es = (v.k == 1) ? v.size : BYTE;
      ed = (v.k == 1) ? v.wdata : (v.wdata >> (8 * (c - 1))) & 32'hFF;
      chk($sformatf("v%0d c%0d r_en", n, c), 32'(r_en), 32'(m && !v.we));
      chk($sformatf("v%0d c%0d w_en", n, c), 32'(w_en), 32'(m && v.we));
      chk($sformatf("v%0d c%0d r_addr", n, c), 32'(r_addr),
          (m && !v.we) ? 32'(ea) : 32'd0);
      chk($sformatf("v%0d c%0d r_sz", n, c), 32'(r_addressing),
          (m && !v.we) ? 32'(es) : 32'd0);
      chk($sformatf("v%0d c%0d w_addr", n, c), 32'(w_addr),
          (m && v.we) ? 32'(ea) : 32'd0);
      chk($sformatf("v%0d c%0d w_sz", n, c), 32'(w_addressing),
          (m && v.we) ? 32'(es) : 32'd0);
      chk($sformatf("v%0d c%0d w_data", n, c), w_data,
          (m && v.we) ? ed : 32'd0);
      chk($sformatf("v%0d c%0d ready", n, c), 32'(req_ready), 32'd0);
      chk($sformatf("v%0d c%0d resp_valid", n, c), 32'(resp_valid),
          32'(c == v.k + 1));
      chk($sformatf("v%0d c%0d rdata", n, c), resp_rdata,
          (c == v.k + 1) ? v.rdata : 32'd0);
      chk($sformatf("v%0d c%0d err", n, c), 32'(resp_err),
          (c == v.k + 1) ? 32'(v.err) : 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    mem_init  = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = WORD;
    req_uns   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    //          we    size     uns   addr   wdata          rdata          err   k
    vecs[0]  = '{1'b0, WORD,    1'b0, 6'd8,  32'h0,         32'h84332211, 1'b0, 1};
    vecs[1]  = '{1'b0, BYTE,    1'b0, 6'd11, 32'h0,         32'hFFFFFF84, 1'b0, 1};
    vecs[2]  = '{1'b0, BYTE,    1'b1, 6'd11, 32'h0,         32'h00000084, 1'b0, 1};
    vecs[3]  = '{1'b0, HALF,    1'b0, 6'd8,  32'h0,         32'h00002211, 1'b0, 1};
    vecs[4]  = '{1'b0, HALF,    1'b0, 6'd10, 32'h0,         32'hFFFF8433, 1'b0, 1};
    vecs[5]  = '{1'b0, HALF,    1'b1, 6'd10, 32'h0,         32'h00008433, 1'b0, 1};
    vecs[6]  = '{1'b0, HALF,    1'b0, 6'd63, 32'h0,         32'hFFFFF080, 1'b0, 2};
    vecs[7]  = '{1'b0, HALF,    1'b1, 6'd63, 32'h0,         32'h0000F080, 1'b0, 2};
    vecs[8]  = '{1'b0, ILLEGAL, 1'b0, 6'd5,  32'h0,         32'h0,        1'b1, 0};
    vecs[9]  = '{1'b0, WORD,    1'b0, 6'd9,  32'h0,         32'h00843322, 1'b0, 4};
    vecs[10] = '{1'b1, WORD,    1'b0, 6'd13, 32'hDEADBEEF,  32'h0,        1'b0, 4};
    vecs[11] = '{1'b0, WORD,    1'b0, 6'd13, 32'h0,         32'hDEADBEEF, 1'b0, 4};
    vecs[12] = '{1'b0, BYTE,    1'b1, 6'd16, 32'h0,         32'h000000DE, 1'b0, 1};
    vecs[13] = '{1'b1, HALF,    1'b0, 6'd20, 32'h55551234,  32'h0,        1'b0, 1};
    vecs[14] = '{1'b1, ILLEGAL, 1'b0, 6'd20, 32'hFFFFFFFF,  32'h0,        1'b1, 0};
    vecs[15] = '{1'b0, HALF,    1'b1, 6'd20, 32'h0,         32'h00001234, 1'b0, 1};
    vecs[16] = '{1'b0, HALF,    1'b0, 6'd21, 32'h0,         32'h00000012, 1'b0, 2};
    vecs[17] = '{1'b1, BYTE,    1'b0, 6'd63, 32'h000000AB,  32'h0,        1'b0, 1};
    vecs[18] = '{1'b0, BYTE,    1'b0, 6'd63, 32'h0,         32'hFFFFFFAB, 1'b0, 1};
    vecs[19] = '{1'b0, WORD,    1'b0, 6'd62, 32'h0,         32'h00F0AB00, 1'b0, 4};
    vecs[20] = '{1'b1, HALF,    1'b0, 6'd63, 32'h0000CAFE,  32'h0,        1'b0, 2};
    vecs[21] = '{1'b0, HALF,    1'b1, 6'd63, 32'h0,         32'h0000CAFE, 1'b0, 2};
    vecs[22] = '{1'b0, WORD,    1'b1, 6'd8,  32'h0,         32'h84332211, 1'b0, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst err", 32'(resp_err), 32'd0);
    chk("rst enables", {30'd0, r_en, w_en}, 32'd0);
    chk("rst addrs", {20'd0, r_addr, w_addr}, 32'd0);
    chk("rst w_data", w_data, 32'd0);
    mem_init = 1'b0;
    rst      = 1'b0;

    for (int i = 0; i < 23; i++) run_vec(vecs[i], i);

    // Split store 0x11223344 to 33, reset lands in its third byte cycle
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = WORD;
    req_uns   = 1'b0;
    req_addr  = 6'd33;
    req_wdata = 32'h11223344;
    chk("abort ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort w_en", 32'(w_en), 32'd0);
    chk("abort ready_rst", 32'(req_ready), 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("abort rst c%0d resp", c), 32'(resp_valid), 32'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("abort post c%0d resp", c), 32'(resp_valid), 32'd0);
      chk($sformatf("abort post c%0d en", c), {30'd0, r_en, w_en}, 32'd0);
      chk($sformatf("abort post c%0d ready", c), 32'(req_ready), 32'd1);
    end
    chk("abort mem33", 32'(mem[33]), 32'h44);
    chk("abort mem34", 32'(mem[34]), 32'h33);
    chk("abort mem35", 32'(mem[35]), 32'h00);
    chk("abort mem36", 32'(mem[36]), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock, i_clk; reset is asynchronous and active-high, port i_reset.
REQ-002 Parameters SHALL be:
- NB_DATA, default 32, data width.
- N_ADDRESS, default 64, number of bytes in the memory.
- NB_ADDRESS, default $clog2(N_ADDRESS), byte address width.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_reset, in, 1, asynchronous active-high reset.
- i_req_valid, in, 1, request valid.
- o_req_ready, out, 1, request accepted when valid and ready are both high.
- i_req_we, in, 1, 1 = store, 0 = load.
- i_req_size, in, 2, access size: 00 word, 01 half, 11 byte, 10 illegal.
- i_req_unsigned, in, 1, zero-extend the load result.
- i_req_addr, in, NB_ADDRESS, byte address.
- i_req_wdata, in, NB_DATA, store data, right-aligned.
- o_resp_valid, out, 1, one-cycle completion pulse.
- o_resp_rdata, out, NB_DATA, extended load data.
- o_resp_err, out, 1, illegal size.
- o_mem_r_addr, o_mem_w_addr, out, NB_ADDRESS, memory addresses.
- o_mem_r_en, o_mem_w_en, out, 1, memory enables.
- o_mem_r_addressing, o_mem_w_addressing, out, 2, memory size codes.
- o_mem_w_data, out, NB_DATA, memory write data.
- i_mem_r_data, in, NB_DATA, asynchronous read data from memory.

Function
REQ-004 The FSM SHALL have four states:
- IDLE: o_req_ready = 1.
- ACCESS: one native-size memory cycle.
- SPLIT: byte memory cycles.
- RESP: o_resp_valid = 1.
o_req_ready SHALL be 0 in every state other than IDLE.
REQ-005 On acceptance in IDLE, the block SHALL capture we, size, unsigned, addr and wdata, then move to:
- RESP if size = 10;
- ACCESS if the access is aligned (word: addr[1:0] = 00; half: addr[0] = 0; byte: always);
- SPLIT otherwise.
REQ-006 In ACCESS, the block SHALL assert exactly one memory enable (r_en or w_en) with addressing = the captured size and addr = the captured addr; w_data = wdata.
REQ-007 In SPLIT, the block SHALL issue N byte accesses (N = 4 for word, 2 for half) on consecutive cycles at address (addr + k) mod N_ADDRESS, k = 0..N-1, with addressing 11.
- Store: w_data = {24'b0, wdata byte k}.
- Load: i_mem_r_data[7:0] SHALL be captured into result byte k.
REQ-008 The load result SHALL be registered at the end of the last memory cycle.
REQ-009 Latency: let c0 be the acceptance cycle and K the number of memory cycles (aligned 1, split N, illegal 0). Memory cycles SHALL occupy c1..cK, and o_resp_valid SHALL be high only in cK+1; RESP SHALL return to IDLE.
REQ-010 Load extension:
- byte: bit 7 replicated into bits 31:8 when signed, zeros when unsigned;
- half: bit 15 replicated into bits 31:16 when signed, zeros when unsigned;
- word: unsigned ignored.
REQ-011 For stores and for errors, o_resp_rdata SHALL be 0; o_resp_err = 1 only for size 10.
REQ-012 Whenever the corresponding enable is low, every memory address, addressing and data output SHALL be 0.
REQ-013 o_resp_rdata and o_resp_err SHALL be 0 outside RESP.
REQ-014 A new request SHALL NOT be accepted before the cycle after RESP, so back-to-back requests accept every K+2 cycles.

Reset
REQ-015 i_reset SHALL force state IDLE and zero all internal registers immediately.
REQ-016 Reset values SHALL be: o_req_ready = 1; every other output = 0.
REQ-017 Reset mid-operation SHALL abort the access: no further memory enables and no response for it.

Structure
REQ-018 Shared package mem_pkg SHALL hold:
- size codes WORD = 00, HALF = 01, BYTE = 11, ILLEGAL = 10;
- FSM state encoding.
mem_pkg SHALL be reused by the memory.
REQ-019 Load extension SHALL be a combinational sub-module named mem_load_ext; the rest of the block SHALL stay in one module.

Verification
REQ-020 The bench SHALL cover these scenarios (N_ADDRESS = 64):
- mem[8..11] = 11,22,33,84 (hex); LW addr 8 -> one r_en cycle, addressing 00, addr 8; in c2, rdata = 0x84332211, err = 0.
- LB addr 11 signed -> 0xFFFFFF84; LBU addr 11 -> 0x00000084; both with response in c2.
- SW 0xDEADBEEF addr 13 -> w_en at addr 13, 14, 15, 16 in c1..c4 with data EF, BE, AD, DE; resp in c5 with rdata = 0.
- mem[63] = 80, mem[0] = F0; LH addr 63 signed -> byte reads at addr 63 then 0; rdata = 0xFFFFF080 in c3.
- size 10 -> no memory enables; resp in c1 with err = 1, rdata = 0.
- Reset asserted in c3 of a split SW -> only 2 bytes written, no resp; ready = 1 after reset release.
